// File: rtl/intersection_scheduler.sv
// Uni Ave / MLK Way phase scheduler with built-in interval timer, latched
// pedestrian request and emergency preempt; lights are a Moore decode of state.
module intersection_scheduler #(
    parameter int unsigned TL_CYC = 20,
    parameter int unsigned TS_CYC = 4,
    parameter int unsigned TW_CYC = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       ped,
    input  logic       emg,
    output logic       ug,
    output logic       uy,
    output logic       ur,
    output logic       mg,
    output logic       my,
    output logic       mr,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pend,
    output logic       st
);

    typedef enum logic [2:0] {
        S_UG   = 3'd0,
        S_UY   = 3'd1,
        S_MG   = 3'd2,
        S_MY   = 3'd3,
        S_PED  = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TL_LIM = CNT_W'(TL_CYC - 1);
    localparam logic [CNT_W-1:0] TS_LIM = CNT_W'(TS_CYC - 1);
    localparam logic [CNT_W-1:0] TW_LIM = CNT_W'(TW_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             tl, ts, tw;

    assign tl = (cnt_q >= TL_LIM);
    assign ts = (cnt_q >= TS_LIM);
    assign tw = (cnt_q >= TW_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_UG;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_UG: begin
                if (emg || (tl && (c || ped_pend_q))) state_d = S_UY;
            end
            S_UY: begin
                if (ts) begin
                    if (emg)             state_d = S_HOLD;
                    else if (ped_pend_q) state_d = S_PED;
                    else if (c)          state_d = S_MG;
                    else                 state_d = S_UG;
                end
            end
            S_MG: begin
                if (emg || tl || !c) state_d = S_MY;
            end
            S_MY: begin
                if (ts) begin
                    if (emg)             state_d = S_HOLD;
                    else if (ped_pend_q) state_d = S_PED;
                    else                 state_d = S_UG;
                end
            end
            S_PED: begin
                if (emg)     state_d = S_HOLD;
                else if (tw) state_d = S_UG;
            end
            S_HOLD: begin
                if (!emg) state_d = S_UG;
            end
            default: state_d = S_UG;
        endcase
    end

    // Timer restarts on every state change so each state sees cnt=0 first.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    end

    // Entering PED clears the request even if ped is pressed on that edge.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (ped && (state_q != S_PED))             ped_pend_d = 1'b1;
        if ((state_d == S_PED) && (state_q != S_PED)) ped_pend_d = 1'b0;
    end

    always_comb begin
        ug   = 1'b0;
        uy   = 1'b0;
        ur   = 1'b0;
        mg   = 1'b0;
        my   = 1'b0;
        mr   = 1'b0;
        walk = 1'b0;
        case (state_q)
            S_UY:   begin uy = 1'b1; mr = 1'b1; end
            S_MG:   begin mg = 1'b1; ur = 1'b1; end
            S_MY:   begin my = 1'b1; ur = 1'b1; end
            S_PED:  begin ur = 1'b1; mr = 1'b1; walk = 1'b1; end
            S_HOLD: begin ur = 1'b1; mr = 1'b1; end
            default: begin ug = 1'b1; mr = 1'b1; end
        endcase
    end

    assign phase    = state_q;
    assign ped_pend = ped_pend_q;
    assign st       = (state_d != state_q);

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: each cycle's stimulus and
// expected phase / ped_pend are queued, then popped and compared mid-cycle.
module tb_intersection_scheduler;

    localparam logic [2:0] P_UG   = 3'd0;
    localparam logic [2:0] P_UY   = 3'd1;
    localparam logic [2:0] P_MG   = 3'd2;
    localparam logic [2:0] P_MY   = 3'd3;
    localparam logic [2:0] P_PED  = 3'd4;
    localparam logic [2:0] P_HOLD = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c = 1'b0, ped = 1'b0, emg = 1'b0;
    logic       ug, uy, ur, mg, my, mr, walk;
    logic [2:0] phase;
    logic       ped_pend, st;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       c;
        logic       ped;
        logic       emg;
        logic [2:0] ph;
        logic       pp;
    } sb_t;

    sb_t sb[$];

    intersection_scheduler #(
        .TL_CYC(20),
        .TS_CYC(4),
        .TW_CYC(8),
        .CNT_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .c       (c),
        .ped     (ped),
        .emg     (emg),
        .ug      (ug),
        .uy      (uy),
        .ur      (ur),
        .mg      (mg),
        .my      (my),
        .mr      (mr),
        .walk    (walk),
        .phase   (phase),
        .ped_pend(ped_pend),
        .st      (st)
    );

    always #5 clk = ~clk;

    // {ug,uy,ur,mg,my,mr,walk} required for each phase code
    function automatic logic [6:0] lights_for(input logic [2:0] ph);
        case (ph)
            3'd1:    return 7'b010_001_0;
            3'd2:    return 7'b001_100_0;
            3'd3:    return 7'b001_010_0;
            3'd4:    return 7'b001_001_1;
            3'd5:    return 7'b001_001_0;
            default: return 7'b100_001_0;
        endcase
    endfunction

    task automatic push(input logic c_i, input logic ped_i, input logic emg_i,
                        input logic [2:0] ph_i, input logic pp_i, input int n);
        sb_t e;
        e.c = c_i; e.ped = ped_i; e.emg = emg_i; e.ph = ph_i; e.pp = pp_i;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Leaves the bench 1 time unit after a rising edge with rst released: cycle 0.
    task automatic apply_reset(input logic c_i);
        c = c_i; ped = 1'b0; emg = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset;
        #12 rst = 1'b0;
        #1;
        total++;
        if ({phase, ug, uy, ur, mg, my, mr, walk} !== {P_UG, lights_for(P_UG)}) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {phase, ug, uy, ur, mg, my, mr, walk},
                     {P_UG, lights_for(P_UG)});
        end
        total++;
        if (ped_pend !== 1'b0) begin
            bad++;
            $display("FAIL reset_ped_pend got=%b exp=0", ped_pend);
        end
    endtask

    task automatic test_idle;
        sb_t e;
        int  n = 0;
        apply_reset(1'b0);
        push(0, 0, 0, P_UG, 0, 200);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = e.c; ped = e.ped; emg = e.emg;
            @(negedge clk);
            total++;
            if ({phase, ug, uy, ur, mg, my, mr, walk} !== {e.ph, lights_for(e.ph)}) begin
                bad++;
                $display("FAIL idle_lights cyc=%0d got=%b exp=%b", n,
                         {phase, ug, uy, ur, mg, my, mr, walk}, {e.ph, lights_for(e.ph)});
            end
            total++;
            if (ped_pend !== e.pp) begin
                bad++;
                $display("FAIL idle_ped_pend cyc=%0d got=%b exp=%b", n, ped_pend, e.pp);
            end
            if (sb.size() > 0) begin
                total++;
                if (st !== (sb[0].ph != e.ph)) begin
                    bad++;
                    $display("FAIL idle_st cyc=%0d got=%b exp=%b", n, st, sb[0].ph != e.ph);
                end
            end
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_car_cycling;
        sb_t e;
        int  n = 0;
        apply_reset(1'b1);
        for (int r = 0; r < 2; r++) begin
            push(1, 0, 0, P_UG, 0, 20);
            push(1, 0, 0, P_UY, 0, 4);
            push(1, 0, 0, P_MG, 0, 20);
            push(1, 0, 0, P_MY, 0, 4);
        end
        push(1, 0, 0, P_UG, 0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = e.c; ped = e.ped; emg = e.emg;
            @(negedge clk);
            total++;
            if ({phase, ug, uy, ur, mg, my, mr, walk} !== {e.ph, lights_for(e.ph)}) begin
                bad++;
                $display("FAIL car_cycle_lights cyc=%0d got=%b exp=%b", n,
                         {phase, ug, uy, ur, mg, my, mr, walk}, {e.ph, lights_for(e.ph)});
            end
            total++;
            if (ped_pend !== e.pp) begin
                bad++;
                $display("FAIL car_cycle_ped_pend cyc=%0d got=%b exp=%b", n, ped_pend, e.pp);
            end
            if (sb.size() > 0) begin
                total++;
                if (st !== (sb[0].ph != e.ph)) begin
                    bad++;
                    $display("FAIL car_cycle_st cyc=%0d got=%b exp=%b", n, st, sb[0].ph != e.ph);
                end
            end
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_car_leaves;
        sb_t e;
        int  n = 0;
        apply_reset(1'b1);
        push(1, 0, 0, P_UG, 0, 20);
        push(1, 0, 0, P_UY, 0, 4);
        push(1, 0, 0, P_MG, 0, 3);
        push(0, 0, 0, P_MG, 0, 1);
        push(0, 0, 0, P_MY, 0, 4);
        push(1, 0, 0, P_UG, 0, 20);
        push(0, 0, 0, P_UY, 0, 4);
        push(0, 0, 0, P_UG, 0, 5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = e.c; ped = e.ped; emg = e.emg;
            @(negedge clk);
            total++;
            if ({phase, ug, uy, ur, mg, my, mr, walk} !== {e.ph, lights_for(e.ph)}) begin
                bad++;
                $display("FAIL car_leaves_lights cyc=%0d got=%b exp=%b", n,
                         {phase, ug, uy, ur, mg, my, mr, walk}, {e.ph, lights_for(e.ph)});
            end
            total++;
            if (ped_pend !== e.pp) begin
                bad++;
                $display("FAIL car_leaves_ped_pend cyc=%0d got=%b exp=%b", n, ped_pend, e.pp);
            end
            if (sb.size() > 0) begin
                total++;
                if (st !== (sb[0].ph != e.ph)) begin
                    bad++;
                    $display("FAIL car_leaves_st cyc=%0d got=%b exp=%b", n, st, sb[0].ph != e.ph);
                end
            end
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_pedestrian;
        sb_t e;
        int  n = 0;
        apply_reset(1'b0);
        push(0, 0, 0, P_UG, 0, 5);
        push(0, 1, 0, P_UG, 0, 1);
        push(0, 0, 0, P_UG, 1, 14);
        push(0, 0, 0, P_UY, 1, 4);
        push(0, 0, 0, P_PED, 0, 2);
        push(0, 1, 0, P_PED, 0, 1);
        push(0, 0, 0, P_PED, 0, 5);
        push(0, 0, 0, P_UG, 0, 5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = e.c; ped = e.ped; emg = e.emg;
            @(negedge clk);
            total++;
            if ({phase, ug, uy, ur, mg, my, mr, walk} !== {e.ph, lights_for(e.ph)}) begin
                bad++;
                $display("FAIL ped_lights cyc=%0d got=%b exp=%b", n,
                         {phase, ug, uy, ur, mg, my, mr, walk}, {e.ph, lights_for(e.ph)});
            end
            total++;
            if (ped_pend !== e.pp) begin
                bad++;
                $display("FAIL ped_ped_pend cyc=%0d got=%b exp=%b", n, ped_pend, e.pp);
            end
            if (sb.size() > 0) begin
                total++;
                if (st !== (sb[0].ph != e.ph)) begin
                    bad++;
                    $display("FAIL ped_st cyc=%0d got=%b exp=%b", n, st, sb[0].ph != e.ph);
                end
            end
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_emergency;
        sb_t e;
        int  n = 0;
        apply_reset(1'b1);
        push(1, 0, 0, P_UG, 0, 20);
        push(1, 0, 0, P_UY, 0, 4);
        push(1, 0, 0, P_MG, 0, 3);
        push(1, 0, 1, P_MG, 0, 1);
        push(1, 0, 1, P_MY, 0, 1);
        push(1, 1, 1, P_MY, 0, 1);
        push(1, 0, 1, P_MY, 1, 2);
        push(0, 0, 1, P_HOLD, 1, 6);
        push(0, 0, 0, P_HOLD, 1, 1);
        push(0, 0, 0, P_UG, 1, 20);
        push(0, 0, 0, P_UY, 1, 4);
        push(0, 0, 0, P_PED, 0, 8);
        push(0, 0, 0, P_UG, 0, 2);
        push(0, 0, 1, P_UG, 0, 1);
        push(0, 0, 1, P_UY, 0, 4);
        push(0, 0, 1, P_HOLD, 0, 1);
        push(0, 0, 0, P_HOLD, 0, 1);
        push(0, 0, 0, P_UG, 0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = e.c; ped = e.ped; emg = e.emg;
            @(negedge clk);
            total++;
            if ({phase, ug, uy, ur, mg, my, mr, walk} !== {e.ph, lights_for(e.ph)}) begin
                bad++;
                $display("FAIL emg_lights cyc=%0d got=%b exp=%b", n,
                         {phase, ug, uy, ur, mg, my, mr, walk}, {e.ph, lights_for(e.ph)});
            end
            total++;
            if (ped_pend !== e.pp) begin
                bad++;
                $display("FAIL emg_ped_pend cyc=%0d got=%b exp=%b", n, ped_pend, e.pp);
            end
            if (sb.size() > 0) begin
                total++;
                if (st !== (sb[0].ph != e.ph)) begin
                    bad++;
                    $display("FAIL emg_st cyc=%0d got=%b exp=%b", n, st, sb[0].ph != e.ph);
                end
            end
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_async_reset;
        sb_t e;
        int  n = 0;
        apply_reset(1'b1);
        push(1, 0, 0, P_UG, 0, 20);
        push(1, 0, 0, P_UY, 0, 4);
        push(1, 0, 0, P_MG, 0, 20);
        push(1, 1, 0, P_MY, 0, 1);
        push(1, 0, 0, P_MY, 1, 2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = e.c; ped = e.ped; emg = e.emg;
            @(negedge clk);
            total++;
            if ({phase, ug, uy, ur, mg, my, mr, walk} !== {e.ph, lights_for(e.ph)}) begin
                bad++;
                $display("FAIL async_lights cyc=%0d got=%b exp=%b", n,
                         {phase, ug, uy, ur, mg, my, mr, walk}, {e.ph, lights_for(e.ph)});
            end
            total++;
            if (ped_pend !== e.pp) begin
                bad++;
                $display("FAIL async_ped_pend cyc=%0d got=%b exp=%b", n, ped_pend, e.pp);
            end
            if (sb.size() > 0) begin
                total++;
                if (st !== (sb[0].ph != e.ph)) begin
                    bad++;
                    $display("FAIL async_st cyc=%0d got=%b exp=%b", n, st, sb[0].ph != e.ph);
                end
            end
            @(posedge clk);
            #1 n++;
        end
        // Now in the last MY cycle, with a pending request latched; reset between edges.
        #2 rst = 1'b0;
        #1;
        total++;
        if ({phase, ug, uy, ur, mg, my, mr, walk} !== {P_UG, lights_for(P_UG)}) begin
            bad++;
            $display("FAIL async_mid_my_outputs got=%b exp=%b",
                     {phase, ug, uy, ur, mg, my, mr, walk}, {P_UG, lights_for(P_UG)});
        end
        total++;
        if (ped_pend !== 1'b0) begin
            bad++;
            $display("FAIL async_mid_my_ped_pend got=%b exp=0", ped_pend);
        end
        total++;
        if (st !== 1'b0) begin
            bad++;
            $display("FAIL async_mid_my_st got=%b exp=0", st);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        test_reset;
        test_idle;
        test_car_cycling;
        test_car_leaves;
        test_pedestrian;
        test_emergency;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
